// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace-debug trigger.
package trdb_pkg;

    localparam int unsigned TRIG_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } trig_state_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a level input; the rise is reported in the same cycle.
module edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/trdb_trigger.sv
// Address/count based trace trigger: arm, start on an address, stop on an
// address, an instruction budget or a disarm request.
module trdb_trigger
    import trdb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  iretire_i,
    input  logic [XLEN-1:0]       iaddr_i,
    input  logic                  cfg_we_i,
    input  logic [XLEN-1:0]       cfg_start_addr_i,
    input  logic [XLEN-1:0]       cfg_stop_addr_i,
    input  logic [TRIG_CNT_W-1:0] cfg_count_i,
    input  logic                  arm_i,
    input  logic                  disarm_i,
    output logic                  trace_req_on_o,
    output logic                  trace_req_off_o,
    output logic                  busy_o,
    output logic [1:0]            state_o,
    output logic [TRIG_CNT_W-1:0] instr_cnt_o
);

    trig_state_e           state_q, state_d;
    logic [TRIG_CNT_W-1:0] cnt_q, cnt_d;
    logic [TRIG_CNT_W-1:0] cnt_lim_q;
    logic [XLEN-1:0]       start_q, stop_q;
    logic                  on_q, off_q, busy_q;

    logic arm_rise, disarm_rise;
    logic start_hit, stop_hit, cnt_hit;

    edge_detect u_arm_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sig_i  (arm_i),
        .rise_o (arm_rise)
    );

    edge_detect u_disarm_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sig_i  (disarm_i),
        .rise_o (disarm_rise)
    );

    assign start_hit = iretire_i & (iaddr_i == start_q);
    assign stop_hit  = iretire_i & (iaddr_i == stop_q);
    assign cnt_hit   = (cnt_lim_q != '0) & (cnt_q >= cnt_lim_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q   <= '0;
            stop_q    <= '0;
            cnt_lim_q <= '0;
        end else if (cfg_we_i && (state_q == IDLE)) begin
            start_q   <= cfg_start_addr_i;
            stop_q    <= cfg_stop_addr_i;
            cnt_lim_q <= cfg_count_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (arm_rise && !disarm_rise) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end
            end
            ARMED: begin
                if (disarm_rise) begin
                    state_d = IDLE;
                end else if (start_hit) begin
                    state_d = ACTIVE;
                    cnt_d   = TRIG_CNT_W'(1);
                end
            end
            ACTIVE: begin
                // The stop instruction itself is traced and counted; exits on
                // budget or disarm do not count the coincident retirement.
                if (iretire_i && !cnt_hit && !disarm_rise && (cnt_q != '1)) begin
                    cnt_d = cnt_q + TRIG_CNT_W'(1);
                end
                if (stop_hit || cnt_hit || disarm_rise) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (disarm_rise) begin
                    state_d = IDLE;
                end else if (arm_rise) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decodes are taken from the next state into dedicated flops so each
    // output switches cleanly on the clock edge, in lock-step with state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            on_q    <= 1'b0;
            off_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            on_q    <= (state_d == ACTIVE);
            off_q   <= (state_d == DONE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign trace_req_on_o  = on_q;
    assign trace_req_off_o = off_q;
    assign busy_o          = busy_q;
    assign state_o         = state_q;
    assign instr_cnt_o     = cnt_q;

endmodule
